// File: rtl/pwm_duty_sequencer.sv
// Duty-register write sequencer: ramp/triangle sweeps plus host writes, host wins on collision.
// All outputs registered; step writes land dwell+1 cycles apart, host writes have 1-cycle latency.
module pwm_duty_sequencer #(
  parameter int DW = 8,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          host_we,
  input  logic [DW-1:0] host_wdata,
  input  logic [1:0]    cfg_mode,
  input  logic [3:0]    cfg_step,
  input  logic [CW-1:0] cfg_dwell,
  input  logic          start,
  input  logic          stop,
  output logic          reg_we,
  output logic [DW-1:0] reg_wdata,
  output logic [DW-1:0] duty,
  output logic          busy,
  output logic          dir,
  output logic          done
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  localparam logic [1:0] M_HOLD = 2'b00;
  localparam logic [1:0] M_DOWN = 2'b10;
  localparam logic [1:0] M_TRI  = 2'b11;

  logic [0:0]    state_q, state_d;
  logic [1:0]    mode_q, mode_d;
  logic [3:0]    step_q, step_d;
  logic [CW-1:0] dwell_q, dwell_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] duty_q, duty_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          we_q, we_d;
  logic          dir_q, dir_d;
  logic          done_q, done_d;

  logic [DW:0]   sum;
  logic [DW-1:0] step_ext;
  logic [DW-1:0] nxt;
  logic [DW-1:0] limit;

  // Saturating step toward the current direction's rail.
  always_comb begin
    step_ext = {{(DW-4){1'b0}}, step_q};
    sum      = {1'b0, duty_q} + {1'b0, step_ext};
    limit    = dir_q ? '0 : '1;
    if (dir_q) begin
      nxt = (duty_q < step_ext) ? '0 : duty_q - step_ext;
    end else begin
      nxt = sum[DW] ? '1 : sum[DW-1:0];
    end
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    step_d  = step_q;
    dwell_d = dwell_q;
    cnt_d   = cnt_q;
    duty_d  = duty_q;
    wdata_d = wdata_q;
    dir_d   = dir_q;
    we_d    = 1'b0;
    done_d  = 1'b0;
    if (en) begin
      if (host_we) begin
        we_d    = 1'b1;
        wdata_d = host_wdata;
        duty_d  = host_wdata;
      end
      if (state_q == IDLE) begin
        if (start && !stop && cfg_mode != M_HOLD) begin
          state_d = RUN;
          mode_d  = cfg_mode;
          step_d  = (cfg_step == 4'd0) ? 4'd1 : cfg_step;
          dwell_d = cfg_dwell;
          cnt_d   = cfg_dwell;
          dir_d   = (cfg_mode == M_DOWN);
        end
      end else if (stop) begin
        state_d = IDLE;
      end else if (host_we) begin
        cnt_d = dwell_q;
      end else if (cnt_q != '0) begin
        cnt_d = cnt_q - 1'b1;
      end else begin
        we_d    = 1'b1;
        wdata_d = nxt;
        duty_d  = nxt;
        cnt_d   = dwell_q;
        if (nxt == limit) begin
          if (mode_q == M_TRI) begin
            // Reverse at either rail; only the bottom reversal marks a completed period.
            dir_d  = ~dir_q;
            done_d = dir_q;
          end else begin
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      mode_q  <= '0;
      step_q  <= '0;
      dwell_q <= '0;
      cnt_q   <= '0;
      duty_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      dir_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      step_q  <= step_d;
      dwell_q <= dwell_d;
      cnt_q   <= cnt_d;
      duty_q  <= duty_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      dir_q   <= dir_d;
      done_q  <= done_d;
    end
  end

  assign reg_we    = we_q;
  assign reg_wdata = wdata_q;
  assign duty      = duty_q;
  assign busy      = (state_q == RUN);
  assign dir       = dir_q;
  assign done      = done_q;

endmodule

// File: tb/tb_pwm_duty_sequencer.sv
// Bench for pwm_duty_sequencer: directed sweeps checked by a cycle model plus literal spot checks.
module tb_pwm_duty_sequencer;

  localparam int DW = 8;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          en = 1'b0;
  logic          host_we = 1'b0;
  logic [DW-1:0] host_wdata = '0;
  logic [1:0]    cfg_mode = '0;
  logic [3:0]    cfg_step = '0;
  logic [CW-1:0] cfg_dwell = '0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          reg_we;
  logic [DW-1:0] reg_wdata;
  logic [DW-1:0] duty;
  logic          busy;
  logic          dir;
  logic          done;

  pwm_duty_sequencer #(.DW(DW), .CW(CW)) dut (
    .clk(clk), .rst(rst), .en(en), .host_we(host_we), .host_wdata(host_wdata),
    .cfg_mode(cfg_mode), .cfg_step(cfg_step), .cfg_dwell(cfg_dwell),
    .start(start), .stop(stop), .reg_we(reg_we), .reg_wdata(reg_wdata),
    .duty(duty), .busy(busy), .dir(dir), .done(done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Model: a sweep is a sequence of writes, one every dwell+1 cycles counted from
  // the start or the last write; values move by step and clamp at 0/255.
  bit m_active = 0;
  int m_mode = 0, m_step = 0, m_dwell = 0, m_since = 0;
  int m_duty = 0, m_dir = 0;
  int e_we = 0, e_wdata = 0, e_done = 0;

  always @(posedge clk or posedge rst) begin
    int v;
    if (rst) begin
      m_active = 0; m_mode = 0; m_step = 0; m_dwell = 0; m_since = 0;
      m_duty = 0; m_dir = 0; e_we = 0; e_wdata = 0; e_done = 0;
    end else begin
      e_we = 0;
      e_done = 0;
      if (en) begin
        if (host_we) begin
          e_we = 1; e_wdata = host_wdata; m_duty = host_wdata;
        end
        if (!m_active) begin
          if (start && !stop && cfg_mode != 0) begin
            m_active = 1; m_mode = cfg_mode;
            m_step = (cfg_step == 0) ? 1 : cfg_step;
            m_dwell = cfg_dwell; m_since = 0;
            m_dir = (cfg_mode == 2) ? 1 : 0;
          end
        end else if (stop) begin
          m_active = 0;
        end else if (host_we) begin
          m_since = 0;
        end else if (m_since < m_dwell) begin
          m_since++;
        end else begin
          v = m_dir ? m_duty - m_step : m_duty + m_step;
          if (v > 255) v = 255;
          if (v < 0) v = 0;
          e_we = 1; e_wdata = v; m_duty = v; m_since = 0;
          if (m_mode == 3) begin
            if (m_dir == 0 && v == 255) m_dir = 1;
            else if (m_dir == 1 && v == 0) begin m_dir = 0; e_done = 1; end
          end else if ((m_mode == 1 && v == 255) || (m_mode == 2 && v == 0)) begin
            e_done = 1; m_active = 0;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("cyc reg_we", reg_we, e_we);
      chk("cyc reg_wdata", reg_wdata, e_wdata);
      chk("cyc duty", duty, m_duty);
      chk("cyc busy", busy, int'(m_active));
      chk("cyc dir", dir, m_dir);
      chk("cyc done", done, e_done);
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic hw(input int v);
    host_we = 1'b1;
    host_wdata = DW'(v);
    tick();
    host_we = 1'b0;
  endtask

  task automatic go(input int mode, input int step, input int dwell);
    cfg_mode = 2'(mode);
    cfg_step = 4'(step);
    cfg_dwell = CW'(dwell);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    #1 rst = 1'b1;
    tick(3);
    rst = 1'b0;
    en = 1'b1;
    chk_on = 1'b1;
    chk("rst reg_we", reg_we, 0);
    chk("rst duty", duty, 0);
    chk("rst busy", busy, 0);

    // Host write, 1-cycle latency
    hw(8'hA5);
    chk("host reg_we", reg_we, 1);
    chk("host reg_wdata", reg_wdata, 8'hA5);
    chk("host duty", duty, 8'hA5);
    chk("host busy", busy, 0);
    tick();
    chk("host single strobe", reg_we, 0);

    // Ignored starts
    go(0, 1, 0);
    chk("mode0 start busy", busy, 0);
    cfg_mode = 2'd1; start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    chk("start+stop busy", busy, 0);

    // Ramp up to saturation
    hw(250);
    go(1, 4, 2);
    chk("up busy", busy, 1);
    tick(2);
    chk("up dwell quiet", reg_we, 0);
    tick();
    chk("up w1 we", reg_we, 1);
    chk("up w1 data", reg_wdata, 254);
    tick(3);
    chk("up w2 data", reg_wdata, 255);
    chk("up done", done, 1);
    chk("up busy drop", busy, 0);
    tick(4);

    // Ramp down, step 0 as 1, dwell 0
    hw(3);
    go(2, 0, 0);
    chk("dn dir", dir, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("dn data", reg_wdata, 2 - i);
    end
    chk("dn done", done, 1);
    chk("dn busy", busy, 0);
    tick(2);

    // Triangle
    hw(8'hF0);
    go(3, 8, 0);
    tick();
    chk("tri F8", reg_wdata, 8'hF8);
    tick();
    chk("tri FF", reg_wdata, 8'hFF);
    chk("tri dir down", dir, 1);
    for (int k = 1; k <= 31; k++) begin
      tick();
      chk("tri down data", reg_wdata, 255 - 8 * k);
    end
    tick();
    chk("tri zero", reg_wdata, 0);
    chk("tri done", done, 1);
    chk("tri dir up", dir, 0);
    chk("tri busy", busy, 1);
    tick();
    chk("tri rebound", reg_wdata, 8);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("stop busy", busy, 0);
    chk("stop no write", reg_we, 0);
    tick(3);

    // Collision: host wins and dwell restarts
    hw(8'h30);
    go(1, 1, 3);
    tick(4);
    chk("col first step", reg_wdata, 8'h31);
    tick(3);
    host_we = 1'b1; host_wdata = 8'h40;
    tick();
    host_we = 1'b0;
    chk("col host we", reg_we, 1);
    chk("col host data", reg_wdata, 8'h40);
    tick(3);
    chk("col quiet", reg_we, 0);
    tick();
    chk("col next step", reg_wdata, 8'h41);
    stop = 1'b1;
    tick();
    stop = 1'b0;

    // Enable pause shifts step timing by 5
    go(1, 1, 3);
    tick(4);
    chk("en first step", reg_wdata, 8'h42);
    tick();
    en = 1'b0;
    tick(5);
    chk("en hold busy", busy, 1);
    en = 1'b1;
    tick(2);
    chk("en quiet", reg_we, 0);
    tick();
    chk("en shifted step we", reg_we, 1);
    chk("en shifted step data", reg_wdata, 8'h43);

    // Asynchronous reset mid-sweep
    tick(2);
    #2 rst = 1'b1;
    #1;
    chk("arst busy", busy, 0);
    chk("arst duty", duty, 0);
    chk("arst wdata", reg_wdata, 0);
    tick(2);
    rst = 1'b0;
    tick(3);
    chk("post rst busy", busy, 0);
    chk("post rst we", reg_we, 0);

    chk_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
